// File: rtl/graph_pkg.sv
// Shared graph types for the topological-sort path: node ids, node counts and
// the scheduler state encoding, also used by the in-degree table and adjacency store.
package graph_pkg;

  localparam int MAX_NODES  = 1024;
  localparam int NODE_WIDTH = $clog2(MAX_NODES);

  typedef logic [NODE_WIDTH-1:0] node_t;
  typedef logic [NODE_WIDTH:0]   count_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_POP,
    ST_ADJ_WAIT,
    ST_DEC_ISSUE,
    ST_DEC_CHECK,
    ST_DEC_WAIT,
    ST_FINISH
  } state_e;

endpackage

// File: rtl/node_fifo.sv
// Synchronous first-word-fall-through FIFO of node ids; the head is readable
// combinationally so the scheduler can pop and use it in the same cycle.
module node_fifo #(
  parameter int DEPTH = graph_pkg::MAX_NODES,
  parameter int WIDTH = graph_pkg::NODE_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign empty    = (cnt_q == '0);

endmodule

// File: rtl/topo_sort_scheduler.sv
// Kahn-algorithm sequencer: scans the in-degree table for sources, then pops
// nodes, streams their out-edges and decrements destinations, emitting topological order.
module topo_sort_scheduler #(
  parameter int MAX_NODES  = 1024,
  parameter int NODE_WIDTH = $clog2(MAX_NODES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NODE_WIDTH:0]   node_count,
  output logic [NODE_WIDTH-1:0] node_sel,
  output logic                  decrement_degree,
  input  logic [NODE_WIDTH-1:0] node_degree,
  output logic                  adj_rd_en,
  output logic [NODE_WIDTH-1:0] adj_rd_node,
  input  logic                  adj_rsp_valid,
  output logic                  adj_rsp_ready,
  input  logic [NODE_WIDTH-1:0] adj_rsp_dst,
  input  logic                  adj_rsp_last,
  input  logic                  adj_rsp_none,
  output logic                  order_valid,
  output logic [NODE_WIDTH-1:0] order_node,
  output logic                  busy,
  output logic                  done,
  output logic                  cycle_detected
);

  import graph_pkg::*;

  localparam logic [NODE_WIDTH-1:0] NODE_ONE = {{(NODE_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [NODE_WIDTH:0]   CNT_ONE  = {{NODE_WIDTH{1'b0}}, 1'b1};

  state_e                  state_q, state_d;
  logic [NODE_WIDTH:0]     count_q, count_d;
  logic [NODE_WIDTH:0]     emitted_q, emitted_d;
  logic [NODE_WIDTH-1:0]   node_sel_q, node_sel_d;
  logic                    eval_valid_q, eval_valid_d;
  logic [NODE_WIDTH-1:0]   eval_node_q, eval_node_d;
  logic                    decrement_q, decrement_d;
  logic                    adj_rd_en_q, adj_rd_en_d;
  logic [NODE_WIDTH-1:0]   adj_rd_node_q, adj_rd_node_d;
  logic                    ready_q, ready_d;
  logic                    order_valid_q, order_valid_d;
  logic [NODE_WIDTH-1:0]   order_node_q, order_node_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    cycle_q, cycle_d;

  logic                    fifo_push;
  logic [NODE_WIDTH-1:0]   fifo_push_data;
  logic                    fifo_pop;
  logic [NODE_WIDTH-1:0]   fifo_head;
  logic                    fifo_empty;

  node_fifo #(
    .DEPTH (MAX_NODES),
    .WIDTH (NODE_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    emitted_d      = emitted_q;
    node_sel_d     = node_sel_q;
    eval_valid_d   = 1'b0;
    eval_node_d    = eval_node_q;
    decrement_d    = 1'b0;
    adj_rd_en_d    = 1'b0;
    adj_rd_node_d  = adj_rd_node_q;
    ready_d        = 1'b0;
    order_valid_d  = 1'b0;
    order_node_d   = order_node_q;
    busy_d         = busy_q;
    done_d         = done_q;
    cycle_d        = cycle_q;
    fifo_push      = 1'b0;
    fifo_push_data = eval_node_q;
    fifo_pop       = 1'b0;

    // Scan results arrive one cycle after each issue, including the drain cycle.
    if (eval_valid_q && (node_degree == '0)) begin
      fifo_push = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          count_d    = node_count;
          emitted_d  = '0;
          done_d     = 1'b0;
          cycle_d    = 1'b0;
          node_sel_d = '0;
          if (node_count == '0) begin
            state_d = ST_FINISH;
          end else begin
            busy_d  = 1'b1;
            state_d = ST_SCAN;
          end
        end
      end

      ST_SCAN: begin
        eval_valid_d = 1'b1;
        eval_node_d  = node_sel_q;
        if ({1'b0, node_sel_q} == (count_q - CNT_ONE)) begin
          state_d = ST_DRAIN;
        end else begin
          node_sel_d = node_sel_q + NODE_ONE;
        end
      end

      ST_DRAIN: state_d = ST_POP;

      ST_POP: begin
        if (fifo_empty) begin
          state_d = ST_FINISH;
        end else begin
          fifo_pop      = 1'b1;
          order_valid_d = 1'b1;
          order_node_d  = fifo_head;
          adj_rd_en_d   = 1'b1;
          adj_rd_node_d = fifo_head;
          emitted_d     = emitted_q + CNT_ONE;
          state_d       = ST_ADJ_WAIT;
        end
      end

      ST_ADJ_WAIT: begin
        if (adj_rsp_valid) begin
          if (adj_rsp_none) begin
            // The none beat stays valid and is accepted during the following POP cycle.
            ready_d = 1'b1;
            state_d = ST_POP;
          end else begin
            node_sel_d  = adj_rsp_dst;
            decrement_d = 1'b1;
            state_d     = ST_DEC_ISSUE;
          end
        end
      end

      ST_DEC_ISSUE: begin
        ready_d = 1'b1;
        state_d = ST_DEC_CHECK;
      end

      ST_DEC_CHECK: begin
        if (node_degree == '0) begin
          fifo_push      = 1'b1;
          fifo_push_data = node_sel_q;
        end
        state_d = adj_rsp_last ? ST_POP : ST_DEC_WAIT;
      end

      ST_DEC_WAIT: begin
        if (adj_rsp_valid) begin
          node_sel_d  = adj_rsp_dst;
          decrement_d = 1'b1;
          state_d     = ST_DEC_ISSUE;
        end
      end

      ST_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        cycle_d = (emitted_q != count_q);
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      count_q       <= '0;
      emitted_q     <= '0;
      node_sel_q    <= '0;
      eval_valid_q  <= 1'b0;
      eval_node_q   <= '0;
      decrement_q   <= 1'b0;
      adj_rd_en_q   <= 1'b0;
      adj_rd_node_q <= '0;
      ready_q       <= 1'b0;
      order_valid_q <= 1'b0;
      order_node_q  <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      cycle_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      emitted_q     <= emitted_d;
      node_sel_q    <= node_sel_d;
      eval_valid_q  <= eval_valid_d;
      eval_node_q   <= eval_node_d;
      decrement_q   <= decrement_d;
      adj_rd_en_q   <= adj_rd_en_d;
      adj_rd_node_q <= adj_rd_node_d;
      ready_q       <= ready_d;
      order_valid_q <= order_valid_d;
      order_node_q  <= order_node_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      cycle_q       <= cycle_d;
    end
  end

  // A post-decrement value of all ones can only come from decrementing a zero degree.
  always @(posedge clk) begin
    if (!rst && (state_q == ST_DEC_CHECK)) begin
      assert (node_degree != '1)
        else $error("degree underflow on node %0d", node_sel_q);
    end
    if (!rst && decrement_q) begin
      assert (!decrement_d)
        else $error("back-to-back decrement");
    end
  end

  assign node_sel         = node_sel_q;
  assign decrement_degree = decrement_q;
  assign adj_rd_en        = adj_rd_en_q;
  assign adj_rd_node      = adj_rd_node_q;
  assign adj_rsp_ready    = ready_q;
  assign order_valid      = order_valid_q;
  assign order_node       = order_node_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign cycle_detected   = cycle_q;

endmodule

// File: tb/tb_topo_sort_scheduler.sv
// Directed bench for topo_sort_scheduler with behavioural in-degree table and
// adjacency store models; checks emitted order, completion flags and handshakes.
module tb_topo_sort_scheduler;

  localparam int MAX_NODES = 1024;
  localparam int NW        = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [NW:0]   node_count = '0;
  logic [NW-1:0] node_sel;
  logic          decrement_degree;
  logic [NW-1:0] node_degree;
  logic          adj_rd_en;
  logic [NW-1:0] adj_rd_node;
  logic          adj_rsp_valid;
  logic          adj_rsp_ready;
  logic [NW-1:0] adj_rsp_dst;
  logic          adj_rsp_last;
  logic          adj_rsp_none;
  logic          order_valid;
  logic [NW-1:0] order_node;
  logic          busy;
  logic          done;
  logic          cycle_detected;

  topo_sort_scheduler #(.MAX_NODES(MAX_NODES), .NODE_WIDTH(NW)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .node_count       (node_count),
    .node_sel         (node_sel),
    .decrement_degree (decrement_degree),
    .node_degree      (node_degree),
    .adj_rd_en        (adj_rd_en),
    .adj_rd_node      (adj_rd_node),
    .adj_rsp_valid    (adj_rsp_valid),
    .adj_rsp_ready    (adj_rsp_ready),
    .adj_rsp_dst      (adj_rsp_dst),
    .adj_rsp_last     (adj_rsp_last),
    .adj_rsp_none     (adj_rsp_none),
    .order_valid      (order_valid),
    .order_node       (order_node),
    .busy             (busy),
    .done             (done),
    .cycle_detected   (cycle_detected)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_mis++;
        $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  // In-degree table: registered read, decrement written back and returned together.
  logic [NW-1:0] deg      [MAX_NODES];
  logic [NW-1:0] init_deg [MAX_NODES];
  logic          load_tbl = 1'b0;

  always @(posedge clk) begin
    if (load_tbl) begin
      deg <= init_deg;
    end else if (decrement_degree) begin
      deg[node_sel] <= deg[node_sel] - 1'b1;
      node_degree   <= deg[node_sel] - 1'b1;
    end else begin
      node_degree <= deg[node_sel];
    end
  end

  // Adjacency store: up to 4 sources with up to 2 out-edges each.
  int   adj_n [4];
  int   adj_d [4][2];
  logic random_gaps = 1'b0;
  int   cur, idx, pend, gap;

  always @(posedge clk) begin
    if (rst) begin
      adj_rsp_valid <= 1'b0;
      pend <= 0;
      idx  <= 0;
      gap  <= 0;
      cur  <= 0;
    end else if (adj_rd_en) begin
      cur  <= int'(adj_rd_node[1:0]);
      pend <= (adj_n[adj_rd_node[1:0]] == 0) ? 1 : adj_n[adj_rd_node[1:0]];
      idx  <= 0;
      gap  <= random_gaps ? int'($urandom_range(0, 5)) : 0;
      adj_rsp_valid <= 1'b0;
    end else if (adj_rsp_valid && adj_rsp_ready) begin
      adj_rsp_valid <= 1'b0;
      idx  <= idx + 1;
      pend <= pend - 1;
      gap  <= random_gaps ? int'($urandom_range(0, 5)) : 0;
    end else if (!adj_rsp_valid && pend > 0) begin
      if (gap == 0) adj_rsp_valid <= 1'b1;
      else          gap <= gap - 1;
    end
  end

  always_comb begin
    adj_rsp_none = (adj_n[cur] == 0);
    adj_rsp_dst  = '0;
    adj_rsp_last = 1'b1;
    if (!adj_rsp_none && idx < 2) begin
      adj_rsp_dst  = NW'(adj_d[cur][idx]);
      adj_rsp_last = (idx == adj_n[cur] - 1);
    end
  end

  // Monitor sampled on the falling edge, away from the active edge.
  logic [NW-1:0] got[$];
  logic [NW-1:0] d3[$];
  int n_rd = 0, n_ov = 0, n_acc = 0, n_viol = 0;
  logic prev_dec = 1'b0;
  logic [NW-1:0] prev_sel = '0;

  always @(negedge clk) begin
    if (order_valid) begin
      got.push_back(order_node);
      n_ov++;
    end
    if (adj_rd_en) n_rd++;
    if (adj_rsp_valid && adj_rsp_ready) n_acc++;
    if (decrement_degree && prev_dec) n_viol++;
    if (prev_dec && prev_sel == NW'(3)) d3.push_back(node_degree);
    prev_dec = decrement_degree;
    prev_sel = node_sel;
  end

  function automatic logic [31:0] got_at(input int i);
    return (i < got.size()) ? 32'(got[i]) : 32'hFFFF;
  endfunction

  function automatic logic [31:0] d3_at(input int i);
    return (i < d3.size()) ? 32'(d3[i]) : 32'hFFFF;
  endfunction

  task automatic clear_graph();
    for (int i = 0; i < MAX_NODES; i++) init_deg[i] = '0;
    for (int i = 0; i < 4; i++) begin
      adj_n[i] = 0;
      adj_d[i][0] = 0;
      adj_d[i][1] = 0;
    end
  endtask

  task automatic load_table();
    @(negedge clk) load_tbl = 1'b1;
    @(negedge clk) load_tbl = 1'b0;
  endtask

  task automatic set_chain();
    clear_graph();
    adj_n[0] = 1; adj_d[0][0] = 1;
    adj_n[1] = 1; adj_d[1][0] = 2;
    init_deg[1] = 10'd1;
    init_deg[2] = 10'd1;
    load_table();
  endtask

  task automatic set_diamond();
    clear_graph();
    adj_n[0] = 2; adj_d[0][0] = 1; adj_d[0][1] = 2;
    adj_n[1] = 1; adj_d[1][0] = 3;
    adj_n[2] = 1; adj_d[2][0] = 3;
    init_deg[1] = 10'd1;
    init_deg[2] = 10'd1;
    init_deg[3] = 10'd2;
    load_table();
  endtask

  task automatic run_sort(input int count, input string tag, output int cycles);
    @(negedge clk);
    start = 1'b1;
    node_count = (NW+1)'(count);
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    while (!done && cycles < 2000) begin
      @(negedge clk);
      cycles++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  int cyc, base, b3, b_rd, b_ov, b_acc, b_viol;

  initial begin
    clear_graph();
    load_table();
    repeat (2) @(negedge clk);
    check("rst_busy",        32'(busy), 0);
    check("rst_done",        32'(done), 0);
    check("rst_order_valid", 32'(order_valid), 0);
    check("rst_adj_rd_en",   32'(adj_rd_en), 0);
    check("rst_decrement",   32'(decrement_degree), 0);
    check("rst_ready",       32'(adj_rsp_ready), 0);
    check("rst_cycle",       32'(cycle_detected), 0);
    check("rst_node_sel",    32'(node_sel), 0);
    rst = 1'b0;

    // Chain 0->1->2
    set_chain();
    base = got.size();
    run_sort(3, "chain", cyc);
    check("chain_count", 32'(got.size() - base), 3);
    check("chain_o0", got_at(base), 0);
    check("chain_o1", got_at(base + 1), 1);
    check("chain_o2", got_at(base + 2), 2);
    check("chain_cycle", 32'(cycle_detected), 0);
    check("chain_busy", 32'(busy), 0);

    // Diamond 0->1, 0->2, 1->3, 2->3
    set_diamond();
    base = got.size(); b3 = d3.size(); b_viol = n_viol;
    run_sort(4, "diamond", cyc);
    check("diamond_count", 32'(got.size() - base), 4);
    for (int i = 0; i < 4; i++) check("diamond_order", got_at(base + i), 32'(i));
    check("diamond_d3_decs", 32'(d3.size() - b3), 2);
    check("diamond_d3_first", d3_at(b3), 1);
    check("diamond_d3_second", d3_at(b3 + 1), 0);
    check("diamond_adjacent_dec", 32'(n_viol - b_viol), 0);
    check("diamond_cycle", 32'(cycle_detected), 0);

    // Cycle 0->1->0 plus isolated node 2
    clear_graph();
    adj_n[0] = 1; adj_d[0][0] = 1;
    adj_n[1] = 1; adj_d[1][0] = 0;
    init_deg[0] = 10'd1;
    init_deg[1] = 10'd1;
    load_table();
    base = got.size();
    run_sort(3, "cyc", cyc);
    check("cyc_count", 32'(got.size() - base), 1);
    check("cyc_o0", got_at(base), 2);
    check("cyc_detected", 32'(cycle_detected), 1);

    // Empty graph
    b_rd = n_rd; b_ov = n_ov;
    run_sort(0, "empty", cyc);
    check("empty_latency_le2", 32'(cyc <= 2), 1);
    check("empty_order_valid", 32'(n_ov - b_ov), 0);
    check("empty_adj_rd", 32'(n_rd - b_rd), 0);
    check("empty_cycle", 32'(cycle_detected), 0);

    // Diamond with random response gaps
    random_gaps = 1'b1;
    set_diamond();
    base = got.size(); b_acc = n_acc; b_viol = n_viol;
    run_sort(4, "gaps", cyc);
    check("gaps_count", 32'(got.size() - base), 4);
    for (int i = 0; i < 4; i++) check("gaps_order", got_at(base + i), 32'(i));
    check("gaps_beats_accepted", 32'(n_acc - b_acc), 5);
    check("gaps_adjacent_dec", 32'(n_viol - b_viol), 0);
    check("gaps_cycle", 32'(cycle_detected), 0);
    random_gaps = 1'b0;

    // Reset during DEC_CHECK, then rerun the chain
    set_chain();
    @(negedge clk);
    start = 1'b1;
    node_count = (NW+1)'(3);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!decrement_degree && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("rstmid_saw_decrement", 32'(decrement_degree), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_busy",        32'(busy), 0);
    check("rstmid_done",        32'(done), 0);
    check("rstmid_decrement",   32'(decrement_degree), 0);
    check("rstmid_ready",       32'(adj_rsp_ready), 0);
    check("rstmid_adj_rd_en",   32'(adj_rd_en), 0);
    check("rstmid_order_valid", 32'(order_valid), 0);
    check("rstmid_node_sel",    32'(node_sel), 0);
    check("rstmid_cycle",       32'(cycle_detected), 0);
    rst = 1'b0;
    set_chain();
    base = got.size();
    run_sort(3, "rerun", cyc);
    check("rerun_count", 32'(got.size() - base), 3);
    check("rerun_o0", got_at(base), 0);
    check("rerun_o1", got_at(base + 1), 1);
    check("rerun_o2", got_at(base + 2), 2);
    check("rerun_cycle", 32'(cycle_detected), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/topo_sort_scheduler.md
Name: topo_sort_scheduler

Overview:
- Kahn-algorithm sequencer on the in-degree table's update interface; it drives node selection and degree decrements into that table.
- Scans all nodes for zero in-degree, queues them, then pops nodes one at a time. For each popped node it streams the out-edges from the adjacency store, decrements each destination, and queues destinations that reach zero.
- Emits nodes in topological order for the downstream path-count DP, and flags a cycle when not every node is emitted.

Parameters:
- MAX_NODES, 1024, node capacity; also the FIFO depth.
- NODE_WIDTH, $clog2(MAX_NODES), node id and degree width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse starting a sort; ignored while busy
- node_count  in  NODE_WIDTH+1  number of nodes (ids 0..node_count-1); sampled on start
- node_sel  out  NODE_WIDTH  node addressed in the in-degree table
- decrement_degree  out  1  decrement node_sel this cycle
- node_degree  in  NODE_WIDTH  degree of the node_sel issued last cycle; post-decrement if decrement was set
- adj_rd_en  out  1  one-cycle request for the out-edges of adj_rd_node
- adj_rd_node  out  NODE_WIDTH  source node of the request
- adj_rsp_valid  in  1  response beat valid; held until accepted
- adj_rsp_ready  out  1  beat accepted when valid&ready
- adj_rsp_dst  in  NODE_WIDTH  destination node of the beat
- adj_rsp_last  in  1  final beat for the request
- adj_rsp_none  in  1  single beat meaning the source has no out-edges; dst is ignored
- order_valid  out  1  one-cycle pulse carrying the next node in sorted order
- order_node  out  NODE_WIDTH  sorted node id
- busy  out  1  high from start until done
- done  out  1  level, high from end of sort until the next start or rst
- cycle_detected  out  1  valid while done is high: emitted count != node_count

Behaviour:
- Reset values: every output is 0, FSM is in IDLE, FIFO is empty, emitted count is 0. rst mid-operation aborts immediately. The table is not restored, so the caller must rebuild degrees before the next start.
- IDLE: on start with node_count=0, go to FINISH. Otherwise latch node_count, clear done, set busy, and go to SCAN.
- SCAN (pipelined):
  - Cycle k drives node_sel=k with decrement_degree=0, for k=0..node_count-1.
  - Cycle k+1 evaluates node_degree for node k and pushes k into the FIFO if it is 0.
  - One drain cycle follows the last issue, then go to POP.
- POP:
  - FIFO empty: go to FINISH.
  - Otherwise pop node n and, in the same cycle, pulse order_valid with order_node=n, pulse adj_rd_en with adj_rd_node=n, and increment the emitted count. Go to ADJ_WAIT.
- ADJ_WAIT:
  - On adj_rsp_valid with none=1: assert ready (handshake) and go to POP.
  - On adj_rsp_valid with none=0: go to DEC_ISSUE.
- DEC_ISSUE: node_sel=adj_rsp_dst, decrement_degree=1, adj_rsp_ready=0.
- DEC_CHECK:
  - adj_rsp_ready=1, consuming the beat.
  - If node_degree==0, push dst.
  - If last, go to POP; otherwise go to DEC_WAIT.
- DEC_WAIT: wait for adj_rsp_valid, then go to DEC_ISSUE.
- Hazard rule: decrement_degree is never high on two consecutive cycles. This avoids the table's read-before-write hazard; the minimum decrement spacing is 2 cycles.
- FINISH: one cycle; set done, busy=0, and cycle_detected=(emitted != node_count). Go to IDLE.
- FIFO:
  - Depth MAX_NODES. Each node is pushed at most once (only at its 1→0 or initial 0 transition), so it cannot overflow.
  - A push and a pop never occur in the same cycle.
- Widths:
  - Emitted count is NODE_WIDTH+1 bits.
  - Decrementing a zero degree is a protocol violation, flagged by a simulation assertion.

Decomposition:
- graph_pkg: node_t (logic [NODE_WIDTH-1:0]), count_t (NODE_WIDTH+1), and the FSM state enum. It is shared with the in-degree table and the adjacency store.
- Sub-module node_fifo (synchronous FIFO of node_t) with push/pop/empty and synchronous active-high clear on rst.

Test Plan:
- Chain 0→1→2, node_count=3: order_node sequence 0,1,2; done=1; cycle_detected=0.
- Diamond 0→1, 0→2, 1→3, 2→3, node_count=4:
  - order 0,1,2,3.
  - node_degree for 3 is 1 after the first decrement and 0 after the second; node 3 is pushed once.
  - decrement_degree is never high on adjacent cycles.
- Cycle 0→1, 1→0 plus isolated node 2, node_count=3: only order_node=2 is emitted; done=1; cycle_detected=1.
- node_count=0: done rises within 2 cycles of start; no order_valid, no adj_rd_en; cycle_detected=0.
- Random 0–5 cycle gaps on adj_rsp_valid for the diamond graph: same order 0,1,2,3; every beat is accepted exactly once.
- rst asserted during DEC_CHECK: the next cycle has all outputs 0 and busy=0; after rebuilding degrees and restarting the chain test, the order is 0,1,2.
